// File: rtl/acc_ir_datapath_pkg.sv
// rtl/acc_ir_datapath_pkg.sv - shared opcode, width and field constants for the execution datapath
// Purpose: opcode encoding and instruction field positions used by the datapath,
//          its ALU and its interface.
// Ports:   none (package).
package acc_ir_datapath_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OPC_W      = 3;

  // Field positions for the default 16-bit instruction word
  localparam int OPC_MSB    = 15;
  localparam int OPC_LSB    = 13;
  localparam int ADDR_MSB   = 12;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

endpackage

// File: rtl/acc_ir_datapath_if.sv
// rtl/acc_ir_datapath_if.sv - controller/bus bundle between CPU controller and execution datapath
// Purpose: groups the controller strobes, the data bus and the datapath results.
// Ports:   master = controller/bus side (drives strobes and data_in),
//          slave  = datapath side (drives opcode, ir_addr, zero, acc, data_out, data_oe).
interface acc_ir_datapath_if
  import acc_ir_datapath_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic                  load_ir;
  logic                  load_acc;
  logic                  datactr_ena;
  logic [DATA_W-1:0]     data_in;
  logic [OPC_W-1:0]      opcode;
  logic [2*DATA_W-4:0]   ir_addr;
  logic                  zero;
  logic [DATA_W-1:0]     acc;
  logic [DATA_W-1:0]     data_out;
  logic                  data_oe;

  modport master (
    output load_ir, load_acc, datactr_ena, data_in,
    input  opcode, ir_addr, zero, acc, data_out, data_oe
  );

  modport slave (
    input  load_ir, load_acc, datactr_ena, data_in,
    output opcode, ir_addr, zero, acc, data_out, data_oe
  );

endinterface

// File: rtl/acc_ir_datapath_alu.sv
// rtl/acc_ir_datapath_alu.sv - combinational accumulator ALU
// Purpose: computes the accumulator value that an update would produce.
// Ports:   opcode  - current instruction opcode
//          acc     - current accumulator
//          data_in - bus operand
//          next_acc- result (acc for non-arithmetic opcodes)
module acc_ir_datapath_alu
  import acc_ir_datapath_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] next_acc
);

  always_comb begin
    next_acc = acc;
    case (opcode_e'(opcode))
      OP_ADD:  next_acc = acc + data_in;  // carry intentionally dropped
      OP_AND:  next_acc = acc & data_in;
      OP_XOR:  next_acc = acc ^ data_in;
      OP_LDA:  next_acc = data_in;
      default: next_acc = acc;            // HLT, SKZ, STO, JMP
    endcase
  end

endmodule

// File: rtl/acc_ir_datapath.sv
// rtl/acc_ir_datapath.sv - instruction register, accumulator and zero flag
// Purpose: assembles the two-byte instruction, applies the ALU once per
//          load_acc burst and presents accumulator data toward the bus.
// Ports:   clk - system clock
//          rst - synchronous active-high reset
//          dp  - acc_ir_datapath_if.slave (strobes and data_in in;
//                opcode, ir_addr, zero, acc, data_out, data_oe out)
module acc_ir_datapath
  import acc_ir_datapath_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  acc_ir_datapath_if.slave     dp
);

  localparam int IR_W   = 2 * DATA_W;
  localparam int ADDR_W = IR_W - OPC_W;

  logic [IR_W-1:0]   ir_q,         ir_d;
  logic              ptr_q,        ptr_d;
  logic [DATA_W-1:0] acc_q,        acc_d;
  logic              zero_q,       zero_d;
  logic              load_acc_r_q, load_acc_r_d;

  logic [DATA_W-1:0] alu_next;
  logic              acc_update;

  acc_ir_datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode   (ir_q[IR_W-1 -: OPC_W]),
    .acc      (acc_q),
    .data_in  (dp.data_in),
    .next_acc (alu_next)
  );

  // Only the rising edge of a load_acc burst updates, so a held strobe
  // cannot double-apply ADD.
  assign acc_update = dp.load_acc & ~load_acc_r_q;

  always_comb begin
    ir_d         = ir_q;
    ptr_d        = 1'b0;          // any gap in load_ir realigns to the high byte
    acc_d        = acc_q;
    zero_d       = zero_q;
    load_acc_r_d = dp.load_acc;

    if (dp.load_ir) begin
      if (!ptr_q) begin
        ir_d[IR_W-1:DATA_W] = dp.data_in;
      end else begin
        ir_d[DATA_W-1:0] = dp.data_in;
      end
      ptr_d = ~ptr_q;
    end

    // zero follows the value being written so it never lags acc
    if (acc_update) begin
      acc_d  = alu_next;
      zero_d = (alu_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q         <= '0;
      ptr_q        <= 1'b0;
      acc_q        <= '0;
      zero_q       <= 1'b1;
      load_acc_r_q <= 1'b0;
    end else begin
      ir_q         <= ir_d;
      ptr_q        <= ptr_d;
      acc_q        <= acc_d;
      zero_q       <= zero_d;
      load_acc_r_q <= load_acc_r_d;
    end
  end

  assign dp.opcode   = ir_q[IR_W-1 -: OPC_W];
  assign dp.ir_addr  = ir_q[ADDR_W-1:0];
  assign dp.zero     = zero_q;
  assign dp.acc      = acc_q;
  assign dp.data_out = acc_q;
  assign dp.data_oe  = dp.datactr_ena;

endmodule

// File: tb/tb_acc_ir_datapath.sv
// tb/tb_acc_ir_datapath.sv - self-checking bench for acc_ir_datapath
module tb_acc_ir_datapath;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  acc_ir_datapath_if #(.DATA_W(8)) dp ();

  acc_ir_datapath #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp)
  );

  always #5 clk = ~clk;

  // Reference model: instruction held as two bytes, plain integer arithmetic
  int  m_hi, m_lo, m_acc;
  bit  m_second, m_zero, m_prev_la;

  function automatic int m_opcode();
    return m_hi / 32;
  endfunction

  function automatic int m_addr();
    return (m_hi % 32) * 256 + m_lo;
  endfunction

  task automatic model_step(input bit r, input bit li, input bit la, input int din);
    int nacc;
    if (r) begin
      m_hi = 0; m_lo = 0; m_second = 0; m_acc = 0; m_zero = 1; m_prev_la = 0;
      return;
    end
    if (la && !m_prev_la) begin
      case (m_opcode())
        2:       nacc = (m_acc + din) % 256;
        3:       nacc = m_acc & din;
        4:       nacc = m_acc ^ din;
        5:       nacc = din;
        default: nacc = m_acc;
      endcase
      m_acc  = nacc;
      m_zero = (nacc == 0);
    end
    if (li) begin
      if (!m_second) m_hi = din; else m_lo = din;
      m_second = !m_second;
    end else begin
      m_second = 0;
    end
    m_prev_la = la;
  endtask

  // One clock: apply inputs, advance model, sample #1 after the edge
  task automatic cyc(input bit r, input bit li, input bit la, input bit de, input int din);
    rst            = r;
    dp.load_ir     = li;
    dp.load_acc    = la;
    dp.datactr_ena = de;
    dp.data_in     = din[7:0];
    model_step(r, li, la, din);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int hi, input int lo);
    cyc(0, 1, 0, 0, hi);
    cyc(0, 1, 0, 0, lo);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic burst(input int din);
    cyc(0, 0, 1, 0, din);
    cyc(0, 0, 1, 0, din);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 8'h55);
    cyc(1, 0, 0, 0, 8'h55);
    n_checks++; if (dp.acc !== 8'h00) begin n_fail++; $display("FAIL reset_acc got=%h exp=00", dp.acc); end
    n_checks++; if (dp.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", dp.zero); end
    n_checks++; if (dp.opcode !== 3'b000) begin n_fail++; $display("FAIL reset_opcode got=%b exp=000", dp.opcode); end
    n_checks++; if (dp.ir_addr !== 13'h0000) begin n_fail++; $display("FAIL reset_ir_addr got=%h exp=0000", dp.ir_addr); end
    n_checks++; if (dp.data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got=%b exp=0", dp.data_oe); end
  endtask

  task automatic test_fetch;
    cyc(0, 1, 0, 0, 8'hA1);
    cyc(0, 1, 0, 0, 8'h23);
    n_checks++; if (dp.opcode !== 3'b101) begin n_fail++; $display("FAIL fetch_opcode got=%b exp=101", dp.opcode); end
    n_checks++; if (dp.ir_addr !== 13'h0123) begin n_fail++; $display("FAIL fetch_ir_addr got=%h exp=0123", dp.ir_addr); end
    cyc(0, 0, 0, 0, 0);
    // pointer must be back on the high byte: a new pair replaces both bytes
    cyc(0, 1, 0, 0, 8'hA4);
    cyc(0, 1, 0, 0, 8'h56);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (dp.ir_addr !== 13'h0456) begin n_fail++; $display("FAIL fetch_realign got=%h exp=0456", dp.ir_addr); end
    // three consecutive load_ir cycles write high, low, high
    cyc(0, 1, 0, 0, 8'h21);
    cyc(0, 1, 0, 0, 8'h11);
    cyc(0, 1, 0, 0, 8'hA2);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if ({dp.opcode, dp.ir_addr} !== 16'hA211) begin n_fail++; $display("FAIL fetch_three got=%h exp=A211", {dp.opcode, dp.ir_addr}); end
  endtask

  task automatic test_lda_add;
    fetch(8'hA0, 8'h00);
    burst(8'h7F);
    n_checks++; if (dp.acc !== 8'h7F) begin n_fail++; $display("FAIL lda_acc got=%h exp=7F", dp.acc); end
    n_checks++; if (dp.zero !== 1'b0) begin n_fail++; $display("FAIL lda_zero got=%b exp=0", dp.zero); end
    fetch(8'h40, 8'h00);
    cyc(0, 0, 1, 0, 8'h81);
    n_checks++; if (dp.acc !== 8'h00 || dp.zero !== 1'b1) begin n_fail++; $display("FAIL add_first got=%h/%b exp=00/1", dp.acc, dp.zero); end
    cyc(0, 0, 1, 0, 8'h81);
    n_checks++; if (dp.acc !== 8'h00) begin n_fail++; $display("FAIL add_held got=%h exp=00", dp.acc); end
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_and_xor;
    fetch(8'hA0, 8'h00);
    burst(8'hF0);
    fetch(8'h60, 8'h00);
    burst(8'h3C);
    n_checks++; if (dp.acc !== 8'h30) begin n_fail++; $display("FAIL and_acc got=%h exp=30", dp.acc); end
    fetch(8'h80, 8'h5C);
    burst(8'h30);
    n_checks++; if (dp.acc !== 8'h00 || dp.zero !== 1'b1) begin n_fail++; $display("FAIL xor_acc got=%h/%b exp=00/1", dp.acc, dp.zero); end
    cyc(0, 1, 0, 0, 8'hE0);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (dp.opcode !== 3'b111) begin n_fail++; $display("FAIL lone_opcode got=%b exp=111", dp.opcode); end
    n_checks++; if (dp.ir_addr !== 13'h005C) begin n_fail++; $display("FAIL lone_ir_addr got=%h exp=005C", dp.ir_addr); end
  endtask

  task automatic test_sto;
    fetch(8'hA0, 8'h00);
    burst(8'h5A);
    fetch(8'hC0, 8'h00);
    dp.datactr_ena = 1'b1;
    #1;
    n_checks++; if (dp.data_oe !== 1'b1) begin n_fail++; $display("FAIL sto_oe got=%b exp=1", dp.data_oe); end
    n_checks++; if (dp.data_out !== 8'h5A) begin n_fail++; $display("FAIL sto_data got=%h exp=5A", dp.data_out); end
    dp.datactr_ena = 1'b0;
    #1;
    n_checks++; if (dp.data_oe !== 1'b0) begin n_fail++; $display("FAIL sto_oe_off got=%b exp=0", dp.data_oe); end
    burst(8'h11);
    n_checks++; if (dp.acc !== 8'h5A) begin n_fail++; $display("FAIL sto_acc got=%h exp=5A", dp.acc); end
    fetch(8'hE0, 8'h00);
    burst(8'h22);
    n_checks++; if (dp.acc !== 8'h5A) begin n_fail++; $display("FAIL jmp_acc got=%h exp=5A", dp.acc); end
    fetch(8'h20, 8'h00);
    burst(8'h33);
    n_checks++; if (dp.acc !== 8'h5A) begin n_fail++; $display("FAIL skz_acc got=%h exp=5A", dp.acc); end
    fetch(8'h00, 8'h00);
    burst(8'h44);
    n_checks++; if (dp.acc !== 8'h5A) begin n_fail++; $display("FAIL hlt_acc got=%h exp=5A", dp.acc); end
  endtask

  task automatic test_reset_mid_burst;
    fetch(8'h40, 8'h00);
    cyc(1, 0, 1, 0, 8'h11);
    n_checks++; if (dp.acc !== 8'h00 || dp.zero !== 1'b1) begin n_fail++; $display("FAIL rst_burst got=%h/%b exp=00/1", dp.acc, dp.zero); end
    // post-reset held cycle is a fresh edge, but ir was cleared to HLT
    cyc(0, 0, 1, 0, 8'h11);
    n_checks++; if (dp.acc !== 8'h00 || dp.opcode !== 3'b000) begin n_fail++; $display("FAIL rst_held got=%h/%b exp=00/000", dp.acc, dp.opcode); end
    cyc(0, 0, 0, 0, 0);
    // the ADD that reset interrupted now applies exactly once
    fetch(8'h40, 8'h00);
    burst(8'h11);
    n_checks++; if (dp.acc !== 8'h11) begin n_fail++; $display("FAIL rst_once got=%h exp=11", dp.acc); end
  endtask

  task automatic test_random;
    bit r, li, la, de;
    int din;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      li  = ($urandom_range(0, 2) != 0);
      la  = ($urandom_range(0, 1) != 0);
      de  = ($urandom_range(0, 1) != 0);
      din = $urandom_range(0, 255);
      cyc(r, li, la, de, din);
      n_checks++; if (dp.acc !== m_acc[7:0]) begin n_fail++; $display("FAIL rnd_acc i=%0d got=%h exp=%h", i, dp.acc, m_acc[7:0]); end
      n_checks++; if (dp.zero !== m_zero) begin n_fail++; $display("FAIL rnd_zero i=%0d got=%b exp=%b", i, dp.zero, m_zero); end
      n_checks++; if (dp.opcode !== 3'(m_opcode())) begin n_fail++; $display("FAIL rnd_opcode i=%0d got=%b exp=%0d", i, dp.opcode, m_opcode()); end
      n_checks++; if (dp.ir_addr !== 13'(m_addr())) begin n_fail++; $display("FAIL rnd_ir_addr i=%0d got=%h exp=%h", i, dp.ir_addr, m_addr()); end
      n_checks++; if (dp.data_out !== m_acc[7:0] || dp.data_oe !== de) begin n_fail++; $display("FAIL rnd_bus i=%0d got=%h/%b exp=%h/%b", i, dp.data_out, dp.data_oe, m_acc[7:0], de); end
    end
  endtask

  initial begin
    dp.load_ir = 0; dp.load_acc = 0; dp.datactr_ena = 0; dp.data_in = '0;
    m_hi = 0; m_lo = 0; m_acc = 0; m_second = 0; m_zero = 1; m_prev_la = 0;
    test_reset;
    test_fetch;
    test_lda_add;
    test_and_xor;
    test_sto;
    test_reset_mid_burst;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
